// File: rtl/rs_dispatch_pkg.sv
// rs_dispatch_pkg: shared widths, tag constant and record types for the RS dispatch stage.
//   INST_TYPE_WIDTH / DATA_WIDTH : op-type and datapath widths
//   DEPTH_DEF / ROB_IDX_W_DEF / RS_IDX_W_DEF : default block sizing
//   NO_TAG   : producer tag meaning "value already available"
//   dec_op_t : one decoded op as held in the dispatch FIFO
//   operand_t: resolved operand (value + outstanding producer tag)
package rs_dispatch_pkg;
    localparam int INST_TYPE_WIDTH = 6;
    localparam int DATA_WIDTH      = 32;
    localparam int DEPTH_DEF       = 16;
    localparam int ROB_IDX_W_DEF   = 4;
    localparam int RS_IDX_W_DEF    = 5;
    localparam logic [DATA_WIDTH-1:0] NO_TAG = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [INST_TYPE_WIDTH-1:0] ordertype;
        logic [DATA_WIDTH-1:0]      pc;
        logic [DATA_WIDTH-1:0]      imm;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [4:0]                 rd;
        logic                       use_rs1;
        logic                       use_rs2;
        logic                       writes_rd;
    } dec_op_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] v;
        logic [DATA_WIDTH-1:0] q;
    } operand_t;
endpackage

// File: rtl/rs_dispatch_if.sv
// rs_dispatch_if: decoder-to-dispatch valid/ready handshake with the decoded op payload.
//   master (decoder) : drives in_valid and the in_* payload, samples in_ready
//   slave  (dispatch): samples in_valid and payload, drives in_ready
interface rs_dispatch_if;
    import rs_dispatch_pkg::*;
    logic                       in_valid;
    logic                       in_ready;
    logic [INST_TYPE_WIDTH-1:0] in_ordertype;
    logic [DATA_WIDTH-1:0]      in_pc;
    logic [DATA_WIDTH-1:0]      in_imm;
    logic [4:0]                 in_rs1;
    logic [4:0]                 in_rs2;
    logic [4:0]                 in_rd;
    logic                       in_use_rs1;
    logic                       in_use_rs2;
    logic                       in_writes_rd;

    modport master (
        output in_valid, in_ordertype, in_pc, in_imm, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_writes_rd,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_ordertype, in_pc, in_imm, in_rs1, in_rs2, in_rd,
               in_use_rs1, in_use_rs2, in_writes_rd,
        output in_ready
    );
endinterface

// File: rtl/rs_dispatch_fifo.sv
// rs_dispatch_fifo: synchronous op FIFO with occupancy count and single-cycle flush.
//   clk, rst (async, active-low)
//   flush_i : empty the queue at the edge (takes priority over push/pop)
//   push_i  : write din_i at the tail (caller guarantees not full)
//   pop_i   : advance the head (caller guarantees not empty)
//   dout_o  : entry at the head; count_o : occupancy 0..DEPTH
module rs_dispatch_fifo
    import rs_dispatch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  dec_op_t                    din_i,
    output dec_op_t                    dout_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dec_op_t       mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = flush_i ? '0 : head_q + AW'(pop_i);
        tail_d  = flush_i ? '0 : tail_q + AW'(push_i);
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset: only slots between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[tail_q] <= din_i;
    end

    assign dout_o  = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/rs_dispatch.sv
// rs_dispatch: buffers decoded ops, resolves operands, allocates a ROB entry and writes one RS slot per cycle.
//   clk, rst (async, active-low), rdy (global enable), Clear_flag (mispredict flush)
//   dec            : decoder handshake + op payload (slave side)
//   rf_* / rob_*   : register-status and ROB lookups for the head op's sources
//   rob_alloc*     : ROB allocation strobe and payload; rf_rename_* : rd rename write
//   RS_unbusy_pos  : free RS slot (all-ones = full); insqueue_to_RS_needchange/r2/RS_s_* : RS insert port
//   RS_to_ROB_* / SLB_to_RS_* : same-cycle result broadcasts used for forwarding
module rs_dispatch
    import rs_dispatch_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF,
    parameter int RS_IDX_W  = RS_IDX_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       Clear_flag,
    rs_dispatch_if.slave               dec,
    output logic [4:0]                 rf_rs1,
    output logic [4:0]                 rf_rs2,
    input  logic [DATA_WIDTH-1:0]      rf_val1,
    input  logic [DATA_WIDTH-1:0]      rf_q1,
    input  logic [DATA_WIDTH-1:0]      rf_val2,
    input  logic [DATA_WIDTH-1:0]      rf_q2,
    output logic [ROB_IDX_W-1:0]       rob_q1,
    output logic [ROB_IDX_W-1:0]       rob_q2,
    input  logic                       rob_ready1,
    input  logic                       rob_ready2,
    input  logic [DATA_WIDTH-1:0]      rob_value1,
    input  logic [DATA_WIDTH-1:0]      rob_value2,
    input  logic                       rob_full,
    input  logic [ROB_IDX_W-1:0]       rob_tail,
    output logic                       rob_alloc,
    output logic [DATA_WIDTH-1:0]      rob_alloc_pc,
    output logic [4:0]                 rob_alloc_rd,
    output logic [INST_TYPE_WIDTH-1:0] rob_alloc_ordertype,
    output logic                       rf_rename_en,
    output logic [4:0]                 rf_rename_rd,
    output logic [DATA_WIDTH-1:0]      rf_rename_tag,
    input  logic [RS_IDX_W-1:0]        RS_unbusy_pos,
    output logic                       insqueue_to_RS_needchange,
    output logic [RS_IDX_W-1:0]        r2,
    output logic [DATA_WIDTH-1:0]      RS_s_vj_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_vk_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_qj_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_qk_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_pc_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_A_r2_,
    output logic [DATA_WIDTH-1:0]      RS_s_reorder_r2_,
    output logic [INST_TYPE_WIDTH-1:0] RS_s_ordertype_r2_,
    output logic                       RS_s_busy_r2_,
    input  logic                       RS_to_ROB_needchange,
    input  logic [ROB_IDX_W-1:0]       b2,
    input  logic [DATA_WIDTH-1:0]      ROB_s_value_b2_,
    input  logic                       SLB_to_RS_needchange,
    input  logic [ROB_IDX_W-1:0]       b4,
    input  logic [DATA_WIDTH-1:0]      SLB_to_RS_loadvalue
);
    localparam int CW = $clog2(DEPTH) + 1;

    dec_op_t         head, din;
    logic [CW-1:0]   count;
    logic            has_op, go, push, flush;
    operand_t        op1, op2;
    logic [DATA_WIDTH-1:0] tail_tag;

    // Priority: unused/x0, register file, RS broadcast, load broadcast, ROB, still pending.
    function automatic operand_t resolve(input logic use_r, input logic [4:0] r,
                                         input logic [DATA_WIDTH-1:0] val, q,
                                         input logic rob_rdy, input logic [DATA_WIDTH-1:0] rob_val);
        operand_t o;
        o = '{v: '0, q: NO_TAG};
        if (!use_r || r == 5'd0) o.v = '0;
        else if (q == NO_TAG) o.v = val;
        else if (RS_to_ROB_needchange && DATA_WIDTH'(b2) == q) o.v = ROB_s_value_b2_;
        else if (SLB_to_RS_needchange && DATA_WIDTH'(b4) == q) o.v = SLB_to_RS_loadvalue;
        else if (rob_rdy) o.v = rob_val;
        else o.q = q;
        return o;
    endfunction

    assign din = '{ordertype: dec.in_ordertype, pc: dec.in_pc, imm: dec.in_imm,
                   rs1: dec.in_rs1, rs2: dec.in_rs2, rd: dec.in_rd,
                   use_rs1: dec.in_use_rs1, use_rs2: dec.in_use_rs2,
                   writes_rd: dec.in_writes_rd};

    assign has_op       = rst && count != '0;
    assign go           = rdy && !Clear_flag && has_op && RS_unbusy_pos != '1 && !rob_full;
    assign flush        = rdy && Clear_flag;
    assign dec.in_ready = rst && count != CW'(DEPTH);
    assign push         = rdy && !Clear_flag && dec.in_valid && dec.in_ready;
    assign tail_tag     = DATA_WIDTH'(rob_tail);

    rs_dispatch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (go),
        .din_i   (din),
        .dout_o  (head),
        .count_o (count)
    );

    always_comb begin
        op1 = resolve(head.use_rs1, head.rs1, rf_val1, rf_q1, rob_ready1, rob_value1);
        op2 = resolve(head.use_rs2, head.rs2, rf_val2, rf_q2, rob_ready2, rob_value2);
    end

    // Lookup addresses are held at zero while the queue is empty so reset shows clean outputs.
    assign rf_rs1 = has_op ? head.rs1 : '0;
    assign rf_rs2 = has_op ? head.rs2 : '0;
    assign rob_q1 = has_op ? rf_q1[ROB_IDX_W-1:0] : '0;
    assign rob_q2 = has_op ? rf_q2[ROB_IDX_W-1:0] : '0;

    assign insqueue_to_RS_needchange = go;
    assign r2                 = go ? RS_unbusy_pos : '0;
    assign RS_s_vj_r2_        = go ? op1.v : '0;
    assign RS_s_qj_r2_        = go ? op1.q : '0;
    assign RS_s_vk_r2_        = go ? op2.v : '0;
    assign RS_s_qk_r2_        = go ? op2.q : '0;
    assign RS_s_pc_r2_        = go ? head.pc : '0;
    assign RS_s_A_r2_         = go ? head.imm : '0;
    assign RS_s_reorder_r2_   = go ? tail_tag : '0;
    assign RS_s_ordertype_r2_ = go ? head.ordertype : '0;
    assign RS_s_busy_r2_      = go;

    assign rob_alloc           = go;
    assign rob_alloc_pc        = go ? head.pc : '0;
    assign rob_alloc_rd        = go ? head.rd : '0;
    assign rob_alloc_ordertype = go ? head.ordertype : '0;

    assign rf_rename_en  = go && head.writes_rd && head.rd != 5'd0;
    assign rf_rename_rd  = rf_rename_en ? head.rd : '0;
    assign rf_rename_tag = rf_rename_en ? tail_tag : '0;
endmodule

// File: tb/tb_rs_dispatch.sv
// tb_rs_dispatch: table-driven operand-resolution vectors plus directed reset/fill/flush/stall sequences.
module tb_rs_dispatch;
    import rs_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        Clear_flag = 1'b0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_val1, rf_q1, rf_val2, rf_q2;
    logic [3:0]  rob_q1, rob_q2;
    logic        rob_ready1, rob_ready2;
    logic [31:0] rob_value1, rob_value2;
    logic        rob_full;
    logic [3:0]  rob_tail;
    logic        rob_alloc;
    logic [31:0] rob_alloc_pc;
    logic [4:0]  rob_alloc_rd;
    logic [5:0]  rob_alloc_ordertype;
    logic        rf_rename_en;
    logic [4:0]  rf_rename_rd;
    logic [31:0] rf_rename_tag;
    logic [4:0]  RS_unbusy_pos;
    logic        insqueue_to_RS_needchange;
    logic [4:0]  r2;
    logic [31:0] RS_s_vj_r2_, RS_s_vk_r2_, RS_s_qj_r2_, RS_s_qk_r2_;
    logic [31:0] RS_s_pc_r2_, RS_s_A_r2_, RS_s_reorder_r2_;
    logic [5:0]  RS_s_ordertype_r2_;
    logic        RS_s_busy_r2_;
    logic        RS_to_ROB_needchange;
    logic [3:0]  b2;
    logic [31:0] ROB_s_value_b2_;
    logic        SLB_to_RS_needchange;
    logic [3:0]  b4;
    logic [31:0] SLB_to_RS_loadvalue;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    rs_dispatch_if dif ();

    rs_dispatch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag), .dec(dif.slave),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_val1(rf_val1), .rf_q1(rf_q1),
        .rf_val2(rf_val2), .rf_q2(rf_q2), .rob_q1(rob_q1), .rob_q2(rob_q2),
        .rob_ready1(rob_ready1), .rob_ready2(rob_ready2),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .rob_full(rob_full), .rob_tail(rob_tail),
        .rob_alloc(rob_alloc), .rob_alloc_pc(rob_alloc_pc), .rob_alloc_rd(rob_alloc_rd),
        .rob_alloc_ordertype(rob_alloc_ordertype),
        .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag),
        .RS_unbusy_pos(RS_unbusy_pos), .insqueue_to_RS_needchange(insqueue_to_RS_needchange),
        .r2(r2), .RS_s_vj_r2_(RS_s_vj_r2_), .RS_s_vk_r2_(RS_s_vk_r2_),
        .RS_s_qj_r2_(RS_s_qj_r2_), .RS_s_qk_r2_(RS_s_qk_r2_), .RS_s_pc_r2_(RS_s_pc_r2_),
        .RS_s_A_r2_(RS_s_A_r2_), .RS_s_reorder_r2_(RS_s_reorder_r2_),
        .RS_s_ordertype_r2_(RS_s_ordertype_r2_), .RS_s_busy_r2_(RS_s_busy_r2_),
        .RS_to_ROB_needchange(RS_to_ROB_needchange), .b2(b2), .ROB_s_value_b2_(ROB_s_value_b2_),
        .SLB_to_RS_needchange(SLB_to_RS_needchange), .b4(b4), .SLB_to_RS_loadvalue(SLB_to_RS_loadvalue)
    );

    typedef struct {
        logic        use_r;
        logic [4:0]  r;
        logic [31:0] val;
        logic [31:0] q;
        logic        rrdy;
        logic [31:0] rval;
        logic        bon;
        logic [3:0]  bt;
        logic [31:0] bval;
        logic        son;
        logic [3:0]  st;
        logic [31:0] sval;
        logic [31:0] ev;
        logic [31:0] eq;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(input logic use_r, input logic [4:0] r, input logic [31:0] val, q,
                                input logic rrdy, input logic [31:0] rval,
                                input logic bon, input logic [3:0] bt, input logic [31:0] bval,
                                input logic son, input logic [3:0] st, input logic [31:0] sval,
                                input logic [31:0] ev, eq);
        vec_t x;
        x.use_r = use_r; x.r = r; x.val = val; x.q = q; x.rrdy = rrdy; x.rval = rval;
        x.bon = bon; x.bt = bt; x.bval = bval; x.son = son; x.st = st; x.sval = sval;
        x.ev = ev; x.eq = eq;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input dec_op_t o);
        dif.in_valid     = v;
        dif.in_ordertype = o.ordertype;
        dif.in_pc        = o.pc;
        dif.in_imm       = o.imm;
        dif.in_rs1       = o.rs1;
        dif.in_rs2       = o.rs2;
        dif.in_rd        = o.rd;
        dif.in_use_rs1   = o.use_rs1;
        dif.in_use_rs2   = o.use_rs2;
        dif.in_writes_rd = o.writes_rd;
    endtask

    task automatic idle_ops();
        rf_val1 = '0; rf_q1 = NO_TAG; rf_val2 = '0; rf_q2 = NO_TAG;
        rob_ready1 = 1'b0; rob_ready2 = 1'b0; rob_value1 = '0; rob_value2 = '0;
        RS_to_ROB_needchange = 1'b0; b2 = '0; ROB_s_value_b2_ = '0;
        SLB_to_RS_needchange = 1'b0; b4 = '0; SLB_to_RS_loadvalue = '0;
    endtask

    initial begin
        dec_op_t op;
        vt[0]  = mk(0, 5'd1, 32'd0,      32'd3,  0, 32'd0, 0, 4'd0,  32'd0,    0, 4'd0, 32'd0,    32'd0,      NO_TAG);
        vt[1]  = mk(1, 5'd0, 32'd0,      32'd3,  0, 32'd0, 0, 4'd0,  32'd0,    0, 4'd0, 32'd0,    32'd0,      NO_TAG);
        vt[2]  = mk(1, 5'd1, 32'd10,     NO_TAG, 0, 32'd0, 0, 4'd0,  32'd0,    0, 4'd0, 32'd0,    32'd10,     NO_TAG);
        vt[3]  = mk(1, 5'd1, 32'd0,      32'd3,  0, 32'd0, 1, 4'd3,  32'h55,   0, 4'd0, 32'd0,    32'h55,     NO_TAG);
        vt[4]  = mk(1, 5'd1, 32'd0,      32'd3,  0, 32'd0, 0, 4'd0,  32'd0,    1, 4'd3, 32'h77,   32'h77,     NO_TAG);
        vt[5]  = mk(1, 5'd2, 32'd0,      32'd3,  0, 32'd0, 1, 4'd2,  32'h55,   1, 4'd3, 32'h77,   32'h77,     NO_TAG);
        vt[6]  = mk(1, 5'd2, 32'd0,      32'd3,  1, 32'd9, 1, 4'd3,  32'h55,   1, 4'd3, 32'h77,   32'h55,     NO_TAG);
        vt[7]  = mk(1, 5'd3, 32'd0,      32'd6,  0, 32'd9, 0, 4'd0,  32'd0,    0, 4'd0, 32'd0,    32'd0,      32'd6);
        vt[8]  = mk(1, 5'd3, 32'd0,      32'd6,  1, 32'd9, 0, 4'd0,  32'd0,    0, 4'd0, 32'd0,    32'd9,      NO_TAG);
        vt[9]  = mk(1, 5'd4, 32'd0,      32'd6,  1, 32'd9, 1, 4'd6,  32'h11,   0, 4'd0, 32'd0,    32'h11,     NO_TAG);
        vt[10] = mk(1, 5'd4, 32'd0,      32'h13, 0, 32'd9, 1, 4'd3,  32'h55,   1, 4'd3, 32'h77,   32'd0,      32'h13);
        vt[11] = mk(1, 5'd31, 32'h1234,  NO_TAG, 0, 32'd0, 1, 4'd15, 32'h99,   1, 4'd15, 32'h88,  32'h1234,   NO_TAG);

        op = '0;
        set_in(1'b0, op);
        idle_ops();
        rob_full = 1'b0; rob_tail = 4'd4; RS_unbusy_pos = 5'd2;

        #1;
        chk("rst_needchange", 32'(insqueue_to_RS_needchange), 32'd0);
        chk("rst_in_ready", 32'(dif.in_ready), 32'd0);
        chk("rst_rob_alloc", 32'(rob_alloc), 32'd0);
        chk("rst_rename_en", 32'(rf_rename_en), 32'd0);
        chk("rst_r2", 32'(r2), 32'd0);
        chk("rst_A", RS_s_A_r2_, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rel_in_ready", 32'(dif.in_ready), 32'd1);

        // reset with three ops queued
        @(negedge clk);
        RS_unbusy_pos = '1;
        for (int i = 0; i < 3; i++) begin
            op.imm = 32'(i);
            set_in(1'b1, op);
            step();
        end
        set_in(1'b0, op);
        RS_unbusy_pos = 5'd2;
        #1 chk("pre_rst_needchange", 32'(insqueue_to_RS_needchange), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_needchange", 32'(insqueue_to_RS_needchange), 32'd0);
        chk("mid_rst_in_ready", 32'(dif.in_ready), 32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("post_rst_needchange", 32'(insqueue_to_RS_needchange), 32'd0);
        chk("post_rst_in_ready", 32'(dif.in_ready), 32'd1);
        @(negedge clk);

        // ADDI x5,x1,7
        op = '0;
        op.ordertype = 6'h13; op.pc = 32'h100; op.imm = 32'd7;
        op.rs1 = 5'd1; op.rd = 5'd5; op.use_rs1 = 1'b1; op.writes_rd = 1'b1;
        set_in(1'b1, op);
        #1 chk("push_cycle_needchange", 32'(insqueue_to_RS_needchange), 32'd0);
        step();
        set_in(1'b0, op);
        rf_q1 = NO_TAG; rf_val1 = 32'd10; rf_q2 = 32'd6;
        #1;
        chk("addi_needchange", 32'(insqueue_to_RS_needchange), 32'd1);
        chk("addi_r2", 32'(r2), 32'd2);
        chk("addi_vj", RS_s_vj_r2_, 32'd10);
        chk("addi_qj", RS_s_qj_r2_, NO_TAG);
        chk("addi_vk", RS_s_vk_r2_, 32'd0);
        chk("addi_qk", RS_s_qk_r2_, NO_TAG);
        chk("addi_A", RS_s_A_r2_, 32'd7);
        chk("addi_pc", RS_s_pc_r2_, 32'h100);
        chk("addi_reorder", RS_s_reorder_r2_, 32'd4);
        chk("addi_type", 32'(RS_s_ordertype_r2_), 32'h13);
        chk("addi_busy", 32'(RS_s_busy_r2_), 32'd1);
        chk("addi_rob_alloc", 32'(rob_alloc), 32'd1);
        chk("addi_rob_pc", rob_alloc_pc, 32'h100);
        chk("addi_rob_rd", 32'(rob_alloc_rd), 32'd5);
        chk("addi_rob_type", 32'(rob_alloc_ordertype), 32'h13);
        chk("addi_rename_en", 32'(rf_rename_en), 32'd1);
        chk("addi_rename_rd", 32'(rf_rename_rd), 32'd5);
        chk("addi_rename_tag", rf_rename_tag, 32'd4);
        chk("addi_rf_rs1", 32'(rf_rs1), 32'd1);
        chk("addi_rob_q2", 32'(rob_q2), 32'd6);
        step();
        idle_ops();
        #1 chk("addi_popped", 32'(insqueue_to_RS_needchange), 32'd0);

        // write to x0 must not rename
        op = '0; op.rd = 5'd0; op.writes_rd = 1'b1; op.imm = 32'd3;
        set_in(1'b1, op);
        step();
        set_in(1'b0, op);
        rob_tail = 4'd9;
        #1;
        chk("x0_rob_alloc", 32'(rob_alloc), 32'd1);
        chk("x0_reorder", RS_s_reorder_r2_, 32'd9);
        chk("x0_rename_en", 32'(rf_rename_en), 32'd0);
        step();
        rob_tail = 4'd4;

        // operand resolution vectors on each source side
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 12; i++) begin
                op = '0;
                op.imm = 32'(i);
                if (s == 0) begin op.rs1 = vt[i].r; op.use_rs1 = vt[i].use_r; end
                else begin op.rs2 = vt[i].r; op.use_rs2 = vt[i].use_r; end
                set_in(1'b1, op);
                step();
                set_in(1'b0, op);
                idle_ops();
                if (s == 0) begin
                    rf_q1 = vt[i].q; rf_val1 = vt[i].val; rob_ready1 = vt[i].rrdy; rob_value1 = vt[i].rval;
                end else begin
                    rf_q2 = vt[i].q; rf_val2 = vt[i].val; rob_ready2 = vt[i].rrdy; rob_value2 = vt[i].rval;
                end
                RS_to_ROB_needchange = vt[i].bon; b2 = vt[i].bt; ROB_s_value_b2_ = vt[i].bval;
                SLB_to_RS_needchange = vt[i].son; b4 = vt[i].st; SLB_to_RS_loadvalue = vt[i].sval;
                #1;
                chk($sformatf("vec%0d_s%0d_need", i, s), 32'(insqueue_to_RS_needchange), 32'd1);
                chk($sformatf("vec%0d_s%0d_v", i, s), s == 0 ? RS_s_vj_r2_ : RS_s_vk_r2_, vt[i].ev);
                chk($sformatf("vec%0d_s%0d_q", i, s), s == 0 ? RS_s_qj_r2_ : RS_s_qk_r2_, vt[i].eq);
                step();
            end
        end
        idle_ops();

        // fill to 16 with RS full, hold a 17th op, then drain in order
        RS_unbusy_pos = '1;
        op = '0;
        for (int i = 0; i < 16; i++) begin
            op.imm = 32'(i);
            set_in(1'b1, op);
            #1 chk($sformatf("fill%0d_ready", i), 32'(dif.in_ready), 32'd1);
            step();
        end
        op.imm = 32'd16;
        set_in(1'b1, op);
        RS_unbusy_pos = 5'd3;
        rob_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("full%0d_ready", k), 32'(dif.in_ready), 32'd0);
            chk($sformatf("full%0d_need", k), 32'(insqueue_to_RS_needchange), 32'd0);
            step();
        end
        rob_full = 1'b0;
        #1;
        chk("free_need", 32'(insqueue_to_RS_needchange), 32'd1);
        chk("free_A", RS_s_A_r2_, 32'd0);
        chk("free_r2", 32'(r2), 32'd3);
        chk("free_ready", 32'(dif.in_ready), 32'd0);
        step();
        #1;
        chk("pushpop_ready", 32'(dif.in_ready), 32'd1);
        chk("pushpop_A", RS_s_A_r2_, 32'd1);
        step();
        set_in(1'b0, op);
        for (int i = 2; i <= 16; i++) begin
            #1;
            chk($sformatf("drain%0d_need", i), 32'(insqueue_to_RS_needchange), 32'd1);
            chk($sformatf("drain%0d_A", i), RS_s_A_r2_, 32'(i));
            step();
        end
        #1 chk("drained_need", 32'(insqueue_to_RS_needchange), 32'd0);
        @(negedge clk);

        // flush with four queued
        RS_unbusy_pos = '1;
        for (int i = 0; i < 4; i++) begin
            op.imm = 32'(100 + i);
            set_in(1'b1, op);
            step();
        end
        op.imm = 32'd200;
        Clear_flag = 1'b1;
        RS_unbusy_pos = 5'd2;
        #1;
        chk("clear_need", 32'(insqueue_to_RS_needchange), 32'd0);
        chk("clear_rob_alloc", 32'(rob_alloc), 32'd0);
        step();
        Clear_flag = 1'b0;
        set_in(1'b0, op);
        #1;
        chk("after_clear_need", 32'(insqueue_to_RS_needchange), 32'd0);
        chk("after_clear_ready", 32'(dif.in_ready), 32'd1);
        step();

        // rdy low freezes
        RS_unbusy_pos = '1;
        op.imm = 32'd300;
        set_in(1'b1, op);
        step();
        op.imm = 32'd301;
        set_in(1'b1, op);
        RS_unbusy_pos = 5'd2;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("rdy0_%0d_need", k), 32'(insqueue_to_RS_needchange), 32'd0);
            chk($sformatf("rdy0_%0d_alloc", k), 32'(rob_alloc), 32'd0);
            step();
        end
        rdy = 1'b1;
        set_in(1'b0, op);
        #1;
        chk("rdy1_need", 32'(insqueue_to_RS_needchange), 32'd1);
        chk("rdy1_A", RS_s_A_r2_, 32'd300);
        step();
        #1 chk("rdy1_empty", 32'(insqueue_to_RS_needchange), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rs_dispatch.md
# rs_dispatch

Issue-side writer for the reservation station: buffers decoded ALU/branch/JALR ops in a FIFO, resolves source operands through the register-status table, ROB and same-cycle result broadcasts, then allocates a ROB entry and writes one RS slot per cycle. It sits between the decoder and the RS, ROB and register-status file. It drives the RS insert port (needchange/r2/RS_s_*_r2_) and consumes RS_unbusy_pos.

## Interface
- DEPTH, 16, FIFO entries (power of 2)
- ROB_IDX_W, 4, ROB index width (matches `ROB_LR_WIDTH)
- RS_IDX_W, 5, RS index width (matches `RS_LR_WIDTH`, MaxRS=32)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- rdy  in  1  global enable; low freezes all state
- Clear_flag  in  1  mispredict flush
- in_valid / in_ready  in / out  1 / 1  decoder handshake
- in_ordertype  in  `INST_TYPE_WIDTH; in_pc, in_imm  in  32; in_rs1, in_rs2, in_rd  in  5; in_use_rs1, in_use_rs2, in_writes_rd  in  1
- rf_rs1, rf_rs2  out  5  register-status read addresses
- rf_val1, rf_q1, rf_val2, rf_q2  in  32  register value / producer tag (-1 = none)
- rob_q1, rob_q2  out  ROB_IDX_W; rob_ready1, rob_ready2  in  1; rob_value1, rob_value2  in  32
- rob_full  in  1; rob_tail  in  ROB_IDX_W  next free ROB tag
- rob_alloc  out  1; rob_alloc_pc  out  32; rob_alloc_rd  out  5; rob_alloc_ordertype  out  `INST_TYPE_WIDTH
- rf_rename_en  out  1; rf_rename_rd  out  5; rf_rename_tag  out  32
- RS_unbusy_pos  in  RS_IDX_W  free slot, all-ones = RS full
- insqueue_to_RS_needchange  out  1; r2  out  RS_IDX_W
- RS_s_vj_r2_, RS_s_vk_r2_, RS_s_qj_r2_, RS_s_qk_r2_, RS_s_pc_r2_, RS_s_A_r2_, RS_s_reorder_r2_  out  32; RS_s_ordertype_r2_  out  `INST_TYPE_WIDTH; RS_s_busy_r2_  out  1
- RS_to_ROB_needchange  in  1; b2  in  ROB_IDX_W; ROB_s_value_b2_  in  32  RS result broadcast
- SLB_to_RS_needchange  in  1; b4  in  ROB_IDX_W; SLB_to_RS_loadvalue  in  32  load broadcast

## Operation
- FIFO: head/tail pointers DEPTH-wrap, count 0..DEPTH. Push when in_valid && in_ready. in_ready = (count != DEPTH) && rst; it does not depend on same-cycle pop.
- go = rdy && !Clear_flag && count != 0 && RS_unbusy_pos != all-ones && !rob_full.
- On go, all combinational from the head entry: insqueue_to_RS_needchange=1; r2=RS_unbusy_pos; busy=1; A=imm; pc=pc; reorder=zero-extended rob_tail; rob_alloc=1; head pops at the edge.
- Operand x (rs1→vj/qj, rs2→vk/qk), first match wins:
  1. use=0 or reg=x0 → v=0, q=-1.
  2. rf_q==-1 → v=rf_val.
  3. RS_to_ROB_needchange && b2==rf_q → ROB_s_value_b2_.
  4. SLB_to_RS_needchange && b4==rf_q → SLB_to_RS_loadvalue.
  5. rob_ready → rob_value.
  6. Otherwise v=0, q=rf_q.
  Resolved cases set q=-1.
- Rename: rf_rename_en = go && writes_rd && rd!=0; tag = zero-extended rob_tail.
- Clear_flag: head=tail=count=0 at the edge; no dispatch or push that cycle.
- rdy low: no push, no pop, all strobes 0.

## Timing
- Reset (rst=0, immediate): pointers and count = 0. All strobes (needchange, rob_alloc, rf_rename_en) = 0. Data outputs = 0; in_ready = 0.
- One dispatch per cycle max. Latency from push to earliest dispatch is 1 cycle; a push into an empty FIFO dispatches on the next cycle.
- Simultaneous push+pop keeps count unchanged. Push at full is refused.
- Broadcast forwarding is same-cycle: a value broadcast on the dispatch cycle is never lost.
- A rename write at edge t is visible to the dispatch at t+1.

## Structure
- Shared package/defines: `INST_TYPE_WIDTH, `DATA_WIDTH, ROB/RS index widths, NO_TAG (32'hFFFFFFFF).
- Sub-module: rs_dispatch_fifo (sync FIFO with count, flush). Operand resolution is an inline function instantiated twice.

## Test plan
- Reset mid-push: assert rst=0 with count=3 → count=0, needchange=0 immediately; in_ready=1 after release.
- ADDI x5,x1,7 with rf_q1=-1, rf_val1=10, RS_unbusy_pos=2, rob_tail=4 → r2=2, vj=10, qj=-1, A=7, reorder=4, rename x5→4.
- rf_q1=3 with same-cycle RS_to_ROB_needchange, b2=3, value=0x55 → vj=0x55, qj=-1. Repeat via SLB b4=3 → vj=loadvalue.
- rf_q2=6, rob_ready2=0, no broadcast → qk=6, vk=0. With rob_ready2=1, value=9 → qk=-1, vk=9.
- RS_unbusy_pos=all-ones or rob_full=1 for 5 cycles → no dispatch, FIFO fills to 16, then in_ready=0. The 17th op is held until space frees.
- Clear_flag with 4 queued → next cycle count=0, no needchange. rdy=0 → state frozen.
